div_arbiter: RTL and testbench

Shares the single 57-bit divider core between up to NREQ frequency-measurement channels (cymometer instances, duty/period units). Each channel posts dividend/divisor with a request; the arbiter grants round-robin, sequences the divider's en/ready/vld_out handshake, and returns quotient/remainder to the granted channel. It sits between the measurement blocks and the divider, on sys_clk.

---
 rtl/div_arbiter_if.sv | 38 +++
 rtl/div_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_div_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// Bundle of the requester-side and divider-side buses of the divider arbiter.
// The slave view belongs to the arbiter; the master view belongs to its environment.
interface div_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 57
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_dividend;
    logic [NREQ*DW-1:0] req_divisor;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    rsp_vld;
    logic               rsp_err;
    logic [DW-1:0]      rsp_quotient;
    logic [DW-1:0]      rsp_remainder;
    logic               busy;

    logic               div_ready;
    logic               div_en;
    logic [DW-1:0]      div_dividend;
    logic [DW-1:0]      div_divisor;
    logic [DW-1:0]      div_quotient;
    logic [DW-1:0]      div_remainder;
    logic               div_vld_out;

    modport slave (
        input  req, req_dividend, req_divisor,
        input  div_ready, div_quotient, div_remainder, div_vld_out,
        output ack, rsp_vld, rsp_err, rsp_quotient, rsp_remainder, busy,
        output div_en, div_dividend, div_divisor
    );

    modport master (
        output req, req_dividend, req_divisor,
        output div_ready, div_quotient, div_remainder, div_vld_out,
        input  ack, rsp_vld, rsp_err, rsp_quotient, rsp_remainder, busy,
        input  div_en, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider core among NREQ measurement channels.
// Sequences the divider handshake, handles divide-by-zero and divider timeout.
module div_arbiter #(
    parameter int         NREQ    = 4,
    parameter int         DW      = 57,
    parameter logic [27:0] TIMEOUT = 28'd200
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    div_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            err_q, err_d;
    logic            rsp_err_q, rsp_err_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
    logic            div_en_q, div_en_d;
    logic [27:0]     tmo_q, tmo_d;

    logic [DW-1:0]   dvd_arr [NREQ];
    logic [DW-1:0]   dvs_arr [NREQ];
    logic            found;
    logic [PW-1:0]   win;
    int              idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign dvd_arr[gi] = bus.req_dividend[gi*DW +: DW];
        assign dvs_arr[gi] = bus.req_divisor[gi*DW +: DW];
    end

    // First requesting channel at or above ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;
        rsp_err_d = rsp_err_q;
        ack_d     = '0;
        rsp_vld_d = '0;
        div_en_d  = div_en_q;
        tmo_d     = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d      = win;
                    ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    dvd_d      = dvd_arr[win];
                    dvs_d      = dvs_arr[win];
                    ack_d[win] = 1'b1;
                    if (dvs_arr[win] != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Divide-by-zero never reaches the core.
                        quo_d   = '1;
                        rem_d   = dvd_arr[win];
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end

            S_ISSUE: begin
                if (bus.div_ready) begin
                    div_en_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                // A result arriving on the timeout cycle is still accepted.
                if (bus.div_vld_out) begin
                    quo_d    = bus.div_quotient;
                    rem_d    = bus.div_remainder;
                    err_d    = 1'b0;
                    div_en_d = 1'b0;
                    state_d  = S_RESP;
                end else if (tmo_q == TIMEOUT - 28'd1) begin
                    quo_d    = '0;
                    rem_d    = '0;
                    err_d    = 1'b1;
                    div_en_d = 1'b0;
                    state_d  = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + 28'd1;
                end
            end

            S_DRAIN: begin
                if (bus.div_ready && !bus.div_vld_out) begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                rsp_vld_d[gnt_q] = 1'b1;
                rsp_err_d        = err_q;
                state_d          = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= DW'(1);
            quo_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            ack_q     <= '0;
            rsp_vld_q <= '0;
            div_en_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            rsp_err_q <= rsp_err_d;
            ack_q     <= ack_d;
            rsp_vld_q <= rsp_vld_d;
            div_en_q  <= div_en_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.rsp_vld       = rsp_vld_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.rsp_quotient  = quo_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.div_en        = div_en_q;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: vector table, hand-written corner sequences and
// randomized rounds against a round-robin/arithmetic reference model.
module tb_div_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 57;
    localparam int LIMIT = 600;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    div_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    div_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(28'd200)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mptr   = 0;
    int lat    = 0;
    int en_cycles = 0;
    int en_total  = 0;
    bit hang      = 1'b0;
    bit force_vld = 1'b0;
    logic [DW-1:0] op_a [NREQ];
    logic [DW-1:0] op_b [NREQ];

    typedef struct {
        int            ch;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        logic [DW-1:0] eq;
        logic [DW-1:0] er;
        logic          ee;
    } vec_t;

    always @(posedge sys_clk) cyc++;

    // Divider stand-in: result valid lat cycles after div_en first goes high.
    always @(negedge sys_clk) begin
        if (bus.div_en === 1'b1) begin
            en_cycles++;
            en_total++;
        end else begin
            en_cycles = 0;
        end
        bus.div_vld_out = force_vld || (!hang && bus.div_en === 1'b1 && en_cycles == lat + 1);
        if (!$isunknown(bus.div_divisor) && bus.div_divisor != '0) begin
            bus.div_quotient  = bus.div_dividend / bus.div_divisor;
            bus.div_remainder = bus.div_dividend % bus.div_divisor;
        end else begin
            bus.div_quotient  = '0;
            bus.div_remainder = '0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_a[ch] = a;
        op_b[ch] = b;
        bus.req_dividend[ch*DW +: DW] = a;
        bus.req_divisor[ch*DW +: DW]  = b;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        int c;
        for (int k = 0; k < NREQ; k++) begin
            c = (p + k) % NREQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic int lowest(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd57();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},     bus.ack, 0);
        chk({tag, "_rsp_vld"}, bus.rsp_vld, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_quo"},     bus.rsp_quotient, 0);
        chk({tag, "_rem"},     bus.rsp_remainder, 0);
        chk({tag, "_busy"},    bus.busy, 0);
        chk({tag, "_div_en"},  bus.div_en, 0);
        chk({tag, "_div_dvd"}, bus.div_dividend, 0);
        chk({tag, "_div_dvs"}, bus.div_divisor, 1);
    endtask

    task automatic wait_ack(output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge sys_clk);
            if (bus.ack != '0) begin
                chk("ack_onehot", $countones(bus.ack), 1);
                idx = lowest(bus.ack);
                at  = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_wait actual=none required=ack within %0d cycles", LIMIT);
    endtask

    task automatic wait_rsp(output int idx, output int at, output logic e,
                            output logic [DW-1:0] q, output logic [DW-1:0] r);
        idx = -1;
        at  = -1;
        e   = 1'bx;
        q   = 'x;
        r   = 'x;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge sys_clk);
            if (bus.rsp_vld != '0) begin
                chk("rsp_onehot", $countones(bus.rsp_vld), 1);
                idx = lowest(bus.rsp_vld);
                at  = cyc;
                e   = bus.rsp_err;
                q   = bus.rsp_quotient;
                r   = bus.rsp_remainder;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL rsp_wait actual=none required=rsp_vld within %0d cycles", LIMIT);
    endtask

    // One transaction: grant predicted from the live req mask and model pointer.
    task automatic serve(output int got, output logic e, output logic [DW-1:0] q,
                         output logic [DW-1:0] r, output int t_ack, output int t_rsp);
        int exp_w;
        int ri;
        exp_w = rr_pick(bus.req, mptr);
        wait_ack(got, t_ack);
        chk("ack_idx", got, exp_w);
        if (exp_w >= 0) mptr = (exp_w + 1) % NREQ;
        if (got >= 0) bus.req[got] = 1'b0;
        wait_rsp(ri, t_rsp, e, q, r);
        chk("rsp_idx", ri, exp_w);
        $display("txn ch=%0d a=%0h b=%0h q=%0h r=%0h err=%0b ack@%0d rsp@%0d",
                 got, (got >= 0) ? op_a[got] : '0, (got >= 0) ? op_b[got] : '0,
                 q, r, e, t_ack, t_rsp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int got, ta, tr, ri, c, n, rsp_seen;
        logic e;
        logic [DW-1:0] q, r, eq, er;
        logic ee;
        logic [NREQ-1:0] m;
        bit seen;

        vecs[0] = '{1, 57'd150_000_000, 57'd3, 20, 57'd50_000_000, 57'd0, 1'b0};
        vecs[1] = '{2, 57'd7, 57'd0, 0, 57'h1FF_FFFF_FFFF_FFFF, 57'd7, 1'b1};
        vecs[2] = '{0, 57'd100, 57'd7, 1, 57'd14, 57'd2, 1'b0};
        vecs[3] = '{3, 57'h1FF_FFFF_FFFF_FFFF, 57'd1, 0, 57'h1FF_FFFF_FFFF_FFFF, 57'd0, 1'b0};
        vecs[4] = '{3, 57'd5, 57'd9, 4, 57'd0, 57'd5, 1'b0};
        vecs[5] = '{0, 57'd1_000_000_007, 57'd1000, 7, 57'd1_000_000, 57'd7, 1'b0};
        vecs[6] = '{2, 57'd0, 57'd0, 3, 57'h1FF_FFFF_FFFF_FFFF, 57'd0, 1'b1};

        bus.req          = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.div_ready    = 1'b1;
        for (int ch = 0; ch < NREQ; ch++) set_ops(ch, '0, '0);

        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        mptr = 0;
        @(negedge sys_clk);
        chk_reset("reset");

        // Vector table: one channel per entry.
        for (int i = 0; i < 7; i++) begin
            set_ops(vecs[i].ch, vecs[i].a, vecs[i].b);
            lat = vecs[i].lat;
            en_total = 0;
            bus.req[vecs[i].ch] = 1'b1;
            serve(got, e, q, r, ta, tr);
            chk("vec_quo", q, vecs[i].eq);
            chk("vec_rem", r, vecs[i].er);
            chk("vec_err", e, vecs[i].ee);
            chk("vec_en_cycles", en_total, (vecs[i].b != '0) ? vecs[i].lat + 1 : 0);
            if (vecs[i].b == '0) chk("divzero_ack_to_rsp", tr - ta, 1);
        end

        // Round-robin with every request held high.
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        mptr = 0;
        for (int ch = 0; ch < NREQ; ch++) set_ops(ch, DW'(1000 + ch), DW'(ch + 1));
        lat = 2;
        bus.req = '1;
        for (int k = 0; k < 8; k++) begin
            c = k % NREQ;
            wait_ack(got, ta);
            chk("rr_ack", got, c);
            if (k == 7) bus.req = '0;
            wait_rsp(ri, tr, e, q, r);
            chk("rr_rsp_idx", ri, c);
            chk("rr_quo", q, DW'((1000 + c) / (c + 1)));
            $display("txn rr k=%0d ack=%0d rsp=%0d q=%0h r=%0h err=%0b", k, got, ri, q, r, e);
        end
        mptr = 0;

        // Backpressure: divider not ready for 30 cycles after ack.
        bus.div_ready = 1'b0;
        set_ops(2, 57'd999, 57'd10);
        lat = 3;
        bus.req[2] = 1'b1;
        wait_ack(got, ta);
        chk("bp_ack", got, 2);
        bus.req = '0;
        mptr = 3;
        n = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (bus.div_en) n++;
        end
        chk("bp_en_held_low", n, 0);
        chk("bp_busy", bus.busy, 1);
        @(posedge sys_clk); #1 bus.div_ready = 1'b1;
        @(negedge sys_clk);
        chk("bp_en_same_cycle", bus.div_en, 0);
        @(negedge sys_clk);
        chk("bp_en_next_cycle", bus.div_en, 1);
        chk("bp_dvd", bus.div_dividend, 999);
        chk("bp_dvs", bus.div_divisor, 10);
        wait_rsp(ri, tr, e, q, r);
        chk("bp_rsp_idx", ri, 2);
        chk("bp_quo", q, 99);
        chk("bp_rem", r, 9);
        chk("bp_err", e, 0);
        $display("txn bp ch=%0d q=%0h r=%0h err=%0b", ri, q, r, e);

        // Timeout with a stray valid during drain.
        hang = 1'b1;
        en_total = 0;
        set_ops(0, 57'd55, 57'd5);
        bus.req[0] = 1'b1;
        wait_ack(got, ta);
        chk("tmo_ack", got, 0);
        bus.req = '0;
        mptr = 1;
        seen = 1'b0;
        n = 0;
        while (n < 400) begin
            @(negedge sys_clk);
            n++;
            if (bus.div_en) seen = 1'b1;
            else if (seen) break;
        end
        chk("tmo_en_cycles", en_total, 200);
        bus.div_ready = 1'b0;
        rsp_seen = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (bus.rsp_vld != '0) rsp_seen++;
        end
        @(posedge sys_clk); #1 force_vld = 1'b1; bus.div_ready = 1'b1;
        @(negedge sys_clk);
        if (bus.rsp_vld != '0) rsp_seen++;
        @(posedge sys_clk); #1 force_vld = 1'b0;
        chk("tmo_drain_no_rsp", rsp_seen, 0);
        wait_rsp(ri, tr, e, q, r);
        chk("tmo_rsp_idx", ri, 0);
        chk("tmo_err", e, 1);
        chk("tmo_quo", q, 0);
        chk("tmo_rem", r, 0);
        $display("txn tmo ch=%0d q=%0h r=%0h err=%0b", ri, q, r, e);
        hang = 1'b0;
        lat = 5;
        set_ops(1, 57'd77, 57'd7);
        bus.req[1] = 1'b1;
        serve(got, e, q, r, ta, tr);
        chk("post_tmo_quo", q, 11);
        chk("post_tmo_err", e, 0);

        // Reset while the divider is busy.
        lat = 50;
        set_ops(1, 57'd500, 57'd4);
        bus.req[1] = 1'b1;
        wait_ack(got, ta);
        chk("rst_ack", got, 1);
        bus.req = '0;
        repeat (5) @(negedge sys_clk);
        chk("rst_en_before", bus.div_en, 1);
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk_reset("midrst");
        mptr = 0;
        n = 0;
        repeat (70) begin
            @(negedge sys_clk);
            if (bus.rsp_vld != '0) n++;
        end
        chk("midrst_no_rsp", n, 0);
        lat = 2;
        set_ops(0, 57'd20, 57'd6);
        set_ops(3, 57'd33, 57'd4);
        bus.req = 4'b1001;
        serve(got, e, q, r, ta, tr);
        chk("midrst_first_ch0", got, 0);
        chk("midrst_quo0", q, 3);
        serve(got, e, q, r, ta, tr);
        chk("midrst_then_ch3", got, 3);
        chk("midrst_quo3", q, 8);
        chk("midrst_rem3", r, 1);

        // Randomized rounds checked against the model.
        for (int rd = 0; rd < 12; rd++) begin
            m   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            lat = $urandom_range(0, 6);
            for (int ch = 0; ch < NREQ; ch++) begin
                if (m[ch]) begin
                    case ($urandom_range(0, 3))
                        0:       set_ops(ch, rnd57(), '0);
                        1:       set_ops(ch, rnd57(), DW'($urandom_range(1, 100)));
                        2:       set_ops(ch, rnd57(), DW'($urandom));
                        default: set_ops(ch, rnd57(), rnd57());
                    endcase
                end
            end
            bus.req = m;
            n = 0;
            while (bus.req != '0 && n < NREQ) begin
                n++;
                serve(got, e, q, r, ta, tr);
                if (got < 0) break;
                if (op_b[got] == '0) begin
                    eq = '1;
                    er = op_a[got];
                    ee = 1'b1;
                end else begin
                    eq = op_a[got] / op_b[got];
                    er = op_a[got] % op_b[got];
                    ee = 1'b0;
                end
                chk("rnd_quo", q, eq);
                chk("rnd_rem", r, er);
                chk("rnd_err", e, ee);
            end
            bus.req = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
